// File: rtl/delay_ff.sv
// Two-stage registered delay line: b is a delayed by one clock, c by two.
// Both outputs come straight from flops, so there is no path from a to b or c.
module delay_ff #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;

    // rst_n keeps its historical name but is active-high; it clears both stages.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_stage1 <= RESET_VALUE;
            r_stage2 <= RESET_VALUE;
        end else begin
            r_stage1 <= a;
            r_stage2 <= r_stage1;
        end
    end

    assign b = r_stage1;
    assign c = r_stage2;

endmodule

// File: tb/tb_delay_ff.sv
// Scoreboard bench for delay_ff: a 1-bit instance and an 8-bit instance with non-zero reset value.
// The driver pushes hand-computed post-edge values; the monitor pops and checks after each edge.
module tb_delay_ff;

    logic       clk;
    logic       rst_n;
    logic       a1;
    logic       b1;
    logic       c1;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] c8;

    delay_ff u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .c     (c1)
    );

    delay_ff #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .c     (c8)
    );

    typedef struct {
        logic       rst;
        logic       a;
        logic [7:0] a8;
        logic       glitch;
        logic       eb;
        logic       ec;
        logic [7:0] eb8;
        logic [7:0] ec8;
    } vec_t;

    typedef struct {
        int         idx;
        logic       eb;
        logic       ec;
        logic [7:0] eb8;
        logic [7:0] ec8;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic a, input logic [7:0] av, input logic glitch,
                       input logic eb, input logic ec, input logic [7:0] eb8, input logic [7:0] ec8);
        vec_t v;
        v.rst = rst; v.a = a; v.a8 = av; v.glitch = glitch;
        v.eb = eb; v.ec = ec; v.eb8 = eb8; v.ec8 = ec8;
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b, expected %b", name, idx, act, req);
        end
    endtask

    task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, req);
        end
    endtask

    // Monitor: one expected entry per rising edge, checked 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check1("b1", e.idx, b1, e.eb);
                check1("c1", e.idx, c1, e.ec);
                check8("b8", e.idx, b8, e.eb8);
                check8("c8", e.idx, c8, e.ec8);
            end
        end
    end

    // Driver
    initial begin
        exp_t e;
        //   rst a   a8     gl  b  c  b8     c8
        // reset for two edges with a toggling; reset beats capture
        add(1, 1, 8'hFF, 0, 0, 0, 8'hA5, 8'hA5);
        add(1, 0, 8'h00, 0, 0, 0, 8'hA5, 8'hA5);
        // single pulse
        add(0, 0, 8'h11, 0, 0, 0, 8'h11, 8'hA5);
        add(0, 1, 8'h22, 0, 1, 0, 8'h22, 8'h11);
        add(0, 0, 8'h33, 0, 0, 1, 8'h33, 8'h22);
        add(0, 0, 8'h44, 0, 0, 0, 8'h44, 8'h33);
        // constant input
        add(0, 1, 8'h55, 0, 1, 0, 8'h55, 8'h44);
        add(0, 1, 8'h55, 0, 1, 1, 8'h55, 8'h55);
        add(0, 1, 8'h55, 0, 1, 1, 8'h55, 8'h55);
        add(0, 1, 8'h55, 0, 1, 1, 8'h55, 8'h55);
        // alternating input
        add(0, 0, 8'h0F, 0, 0, 1, 8'h0F, 8'h55);
        add(0, 1, 8'hF0, 0, 1, 0, 8'hF0, 8'h0F);
        add(0, 0, 8'h0F, 0, 0, 1, 8'h0F, 8'hF0);
        add(0, 1, 8'hF0, 0, 1, 0, 8'hF0, 8'h0F);
        add(0, 1, 8'h3C, 0, 1, 1, 8'h3C, 8'hF0);
        // reset mid-stream with b=1, c=1, then recovery with a=1
        add(1, 1, 8'hC3, 0, 0, 0, 8'hA5, 8'hA5);
        add(0, 1, 8'hC3, 0, 1, 0, 8'hC3, 8'hA5);
        add(0, 1, 8'hC3, 0, 1, 1, 8'hC3, 8'hC3);
        // drain, then glitch between edges
        add(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'hC3);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        add(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            rst_n = vecs[i].rst;
            a1    = vecs[i].a;
            a8    = vecs[i].a8;
            e.idx = i;
            e.eb  = vecs[i].eb;
            e.ec  = vecs[i].ec;
            e.eb8 = vecs[i].eb8;
            e.ec8 = vecs[i].ec8;
            exp_q.push_back(e);
            if (vecs[i].glitch) begin
                #1 a1 = 1'b1; a8 = 8'hFF;
                #2 a1 = 1'b0; a8 = 8'h00;
            end
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
